// File: rtl/tl_safety_monitor.sv
// tl_safety_monitor
//   Sits between the traffic-light controller and the lamp drivers. Every cycle
//   it checks the controller's 16 lamp signals for conflicting greens and for
//   heads that do not show exactly one lamp. A violation that lasts
//   T_FILTER_CYC consecutive cycles latches the monitor into a fault mode. In
//   fault mode the monitor drives flashing yellow on all vehicle heads and red
//   on both pedestrian heads. The monitor returns to pass-through only after
//   fault_clear has been held for CLR_CYC cycles while the controller shows a
//   clean all-red.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   lamps_in     [15:0] controller lamps. Per axis (A = bits 7:0, B = bits 15:8):
//                straight r/y/g, left r/y/g, ped r/g
//   fault_clear  operator clear request (level)
//   lamps_out    [15:0] registered lamp driver outputs, same bit map as lamps_in
//   fault        high while the monitor is latched (FAULT or CLEARING)
//   fault_code   [2:0] code of the violation that tripped, 0 when none
//   fault_count  [7:0] saturating count of entries into FAULT
//
// state    | meaning
// ---------+---------------------------------------------------------------
// NORMAL   | pass-through, filtering raw violations
// FAULT    | latched, flashing yellow, waiting for clear + all-red
// CLEARING | latched, flashing yellow, counting a qualifying clear hold
module tl_safety_monitor #(
  parameter int F_CLK_HZ     = 50_000_000,
  parameter int T_FLASH_MS   = 500,
  parameter int T_FILTER_CYC = 4,
  parameter int T_CLEAR_MS   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] lamps_in,
  input  logic        fault_clear,
  output logic [15:0] lamps_out,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [7:0]  fault_count
);

  localparam int HALF_CYC = F_CLK_HZ / 1000 * T_FLASH_MS;
  localparam int CLR_CYC  = F_CLK_HZ / 1000 * T_CLEAR_MS;
  localparam int HW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam int CW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam int FW = (T_FILTER_CYC > 1) ? $clog2(T_FILTER_CYC) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYC - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(T_FILTER_CYC - 1);
  localparam logic [15:0]   ALL_RED   = 16'h4949;

  typedef enum logic [1:0] {NORMAL, FAULT, CLEARING} state_t;

  state_t         state_q, state_d;
  logic [FW-1:0]  filt_cnt;
  logic [CW-1:0]  clr_cnt;
  logic [HW-1:0]  flash_cnt, flash_cnt_d;
  logic           flash_on, flash_on_d, flash_wrap;
  logic           c1, c2, c3, c4, viol, qual, trip, leave;
  logic [2:0]     code;

  function automatic logic one_of3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Fail-safe pattern: vehicle yellows follow the flash phase, ped reds solid.
  function automatic logic [15:0] flash_pat(input logic on);
    logic [15:0] p;
    p = 16'h4040;
    p[1]  = on;
    p[4]  = on;
    p[9]  = on;
    p[12] = on;
    return p;
  endfunction

  always_comb begin
    c1 = lamps_in[2] & lamps_in[10];
    c2 = lamps_in[5] & lamps_in[13];
    c3 = (lamps_in[7] & (lamps_in[10] | lamps_in[13])) |
         (lamps_in[15] & (lamps_in[2] | lamps_in[5]));
    c4 = !one_of3(lamps_in[2:0])   | !one_of3(lamps_in[5:3])   | !(lamps_in[6] ^ lamps_in[7]) |
         !one_of3(lamps_in[10:8])  | !one_of3(lamps_in[13:11]) | !(lamps_in[14] ^ lamps_in[15]);
    viol = c1 | c2 | c3 | c4;
    if (c1)      code = 3'd1;
    else if (c2) code = 3'd2;
    else if (c3) code = 3'd3;
    else if (c4) code = 3'd4;
    else         code = 3'd0;
  end

  assign qual        = fault_clear & (lamps_in == ALL_RED);
  assign flash_wrap  = (flash_cnt == HALF_LAST);
  assign flash_cnt_d = flash_wrap ? '0 : flash_cnt + HW'(1);
  assign flash_on_d  = flash_on ^ flash_wrap;
  assign fault       = (state_q != NORMAL);

  // The FAULT cycle that first sees a qualifying clear already counts as one
  // hold cycle, so FAULT and CLEARING share the same clear-count decision.
  // clr_cnt is always zero in FAULT.
  always_comb begin
    state_d = state_q;
    trip    = 1'b0;
    leave   = 1'b0;
    case (state_q)
      NORMAL: begin
        if (viol && (filt_cnt == FILT_LAST)) begin
          state_d = FAULT;
          trip    = 1'b1;
        end
      end
      FAULT, CLEARING: begin
        if (!qual) begin
          state_d = FAULT;
        end else if (clr_cnt == CLR_LAST) begin
          state_d = NORMAL;
          leave   = 1'b1;
        end else begin
          state_d = CLEARING;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= NORMAL;
      lamps_out   <= ALL_RED;
      fault_code  <= 3'd0;
      fault_count <= 8'd0;
      filt_cnt    <= '0;
      clr_cnt     <= '0;
      flash_cnt   <= '0;
      flash_on    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == NORMAL) begin
        clr_cnt <= '0;
        if (trip) begin
          lamps_out  <= flash_pat(1'b1);
          fault_code <= code;
          if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
          filt_cnt   <= '0;
          flash_cnt  <= '0;
          flash_on   <= 1'b1;
        end else begin
          lamps_out <= lamps_in;
          filt_cnt  <= viol ? filt_cnt + FW'(1) : '0;
        end
      end else begin
        flash_cnt <= flash_cnt_d;
        flash_on  <= flash_on_d;
        if (leave) begin
          lamps_out  <= lamps_in;
          fault_code <= 3'd0;
          filt_cnt   <= '0;
          clr_cnt    <= '0;
        end else begin
          lamps_out <= flash_pat(flash_on_d);
          clr_cnt   <= qual ? clr_cnt + CW'(1) : '0;
        end
      end
    end
  end

endmodule
